fmps_read_link: RTL and testbench

- Receive-side FMPS link reader. Parses AXI-stream FMPS packets (header plus data words) arriving on the Aurora user clock, as produced upstream by writeFMPSTestLink.
- Stores the last data word of each packet in a buffer indexed by the FMPS index carried in the header.
- Tracks which indices arrived in the current fast-acquisition (FA) cycle and reports a per-cycle status at each FA strobe.
- A readout port lets the consumer fetch stored words by index.

---
 rtl/fmps_read_link.sv | 141 ++++++++++++++
 tb/tb_fmps_read_link.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmps_read_link.sv
// Receive-side FMPS link reader: parses header+data packets, stores the last data
// word per FMPS index, and summarises each fast-acquisition cycle at FAstrobe.
module fmps_read_link #(
   parameter int                   INDEX_WIDTH     = 5,
   parameter int                   INDEX_START_BIT = 10,
   parameter int                   MAGIC_WIDTH     = 16,
   parameter int                   MAGIC_START_BIT = 16,
   parameter logic [MAGIC_WIDTH-1:0] HEADER_MAGIC  = 16'hB6CF,
   parameter int                   NUM_DATA_WORDS  = 1
) (
   input  logic                          auroraClk,
   input  logic                          auroraReset,
   input  logic                          FAstrobe,
   input  logic                          allFMPSpresent,
   input  logic                          TVALID,
   input  logic                          TLAST,
   input  logic [31:0]                   TDATA,
   output logic                          statusStrobe,
   output logic [1:0]                    statusCode,
   output logic                          statusFMPSenabled,
   output logic [(1<<INDEX_WIDTH)-1:0]   fmpsBitmap,
   output logic [INDEX_WIDTH:0]          fmpsCounter,
   input  logic [INDEX_WIDTH-1:0]        readoutAddress,
   output logic [31:0]                   readoutFMPS
);

   localparam int DEPTH = 1 << INDEX_WIDTH;

   typedef enum logic [1:0] {S_HEADER, S_DATA, S_DRAIN} state_t;

   state_t                 state;
   logic [INDEX_WIDTH-1:0] idx_q;
   logic [3:0]             word_cnt;
   logic [3:0]             word_nxt;
   logic [31:0]            data_q;
   logic                   good_pend;
   logic                   err_flag;
   logic                   freeze;
   logic                   hdr_ok;
   logic                   parse_err;
   logic                   pkt_done;
   logic [31:0]            buffer [DEPTH];

   logic [DEPTH-1:0]       bitmap_base;
   logic [INDEX_WIDTH:0]   cnt_base;
   logic                   frz_eff;
   logic                   commit_ok;
   logic                   dup;

   assign hdr_ok   = (TDATA[MAGIC_START_BIT +: MAGIC_WIDTH] == HEADER_MAGIC);
   assign word_nxt = word_cnt + 4'd1;

   always_comb begin
      parse_err = 1'b0;
      pkt_done  = 1'b0;
      if (TVALID) begin
         case (state)
            S_HEADER: if (!hdr_ok || TLAST) parse_err = 1'b1;
            S_DATA: begin
               if (TLAST) begin
                  if (word_nxt == 4'(NUM_DATA_WORDS)) pkt_done  = 1'b1;
                  else                                parse_err = 1'b1;
               end else if (word_nxt == 4'(NUM_DATA_WORDS)) begin
                  parse_err = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // A commit landing on the strobe edge is judged against the new cycle's
   // (cleared) bitmap and freeze, so it belongs to the new cycle.
   assign bitmap_base = FAstrobe ? '0 : fmpsBitmap;
   assign cnt_base    = FAstrobe ? '0 : fmpsCounter;
   assign frz_eff     = freeze & ~FAstrobe;
   assign commit_ok   = good_pend & ~frz_eff & ~bitmap_base[idx_q];
   assign dup         = good_pend & ~frz_eff &  bitmap_base[idx_q];

   always_ff @(posedge auroraClk) begin
      if (auroraReset) begin
         state             <= S_HEADER;
         idx_q             <= '0;
         word_cnt          <= '0;
         data_q            <= '0;
         good_pend         <= 1'b0;
         err_flag          <= 1'b0;
         freeze            <= 1'b0;
         fmpsBitmap        <= '0;
         fmpsCounter       <= '0;
         statusStrobe      <= 1'b0;
         statusCode        <= 2'd0;
         statusFMPSenabled <= 1'b0;
         readoutFMPS       <= '0;
      end else begin
         good_pend <= pkt_done;
         if (TVALID) begin
            case (state)
               S_HEADER: begin
                  if (hdr_ok && !TLAST) begin
                     idx_q    <= TDATA[INDEX_START_BIT +: INDEX_WIDTH];
                     word_cnt <= '0;
                     state    <= S_DATA;
                  end else if (!TLAST) begin
                     state <= S_DRAIN;
                  end
               end
               S_DATA: begin
                  word_cnt <= word_nxt;
                  data_q   <= TDATA;
                  if (TLAST)                                 state <= S_HEADER;
                  else if (word_nxt == 4'(NUM_DATA_WORDS))   state <= S_DRAIN;
               end
               default: if (TLAST) state <= S_HEADER;
            endcase
         end

         err_flag    <= (err_flag & ~FAstrobe) | parse_err | dup;
         freeze      <= FAstrobe ? 1'b0 : (freeze | allFMPSpresent);
         fmpsBitmap  <= bitmap_base | (commit_ok ? (DEPTH'(1) << idx_q) : '0);
         fmpsCounter <= cnt_base + (INDEX_WIDTH+1)'(commit_ok);

         statusStrobe <= FAstrobe;
         if (FAstrobe) begin
            statusCode        <= err_flag ? 2'd2 : (freeze ? 2'd0 : 2'd1);
            statusFMPSenabled <= (fmpsCounter != '0);
         end else begin
            statusCode        <= 2'd0;
            statusFMPSenabled <= 1'b0;
         end

         readoutFMPS <= buffer[readoutAddress];
      end
   end

   // Storage is not reset; fmpsBitmap says which entries are valid.
   always_ff @(posedge auroraClk) begin
      if (!auroraReset && commit_ok) buffer[idx_q] <= data_q;
   end

endmodule

// File: tb/tb_fmps_read_link.sv
// Self-checking bench for fmps_read_link: table of good packets, scoreboard of
// expected buffer contents, and hand sequences for error/freeze/strobe corners.
module tb_fmps_read_link;

   logic        auroraClk = 1'b0;
   logic        auroraReset;
   logic        FAstrobe;
   logic        allFMPSpresent;
   logic        TVALID;
   logic        TLAST;
   logic [31:0] TDATA;
   logic        statusStrobe;
   logic [1:0]  statusCode;
   logic        statusFMPSenabled;
   logic [31:0] fmpsBitmap;
   logic [5:0]  fmpsCounter;
   logic [4:0]  readoutAddress;
   logic [31:0] readoutFMPS;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
      int          exp_cnt;
   } vec_t;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } exp_t;

   vec_t vt [12];
   exp_t sb [$];

   fmps_read_link dut (
      .auroraClk(auroraClk), .auroraReset(auroraReset), .FAstrobe(FAstrobe),
      .allFMPSpresent(allFMPSpresent), .TVALID(TVALID), .TLAST(TLAST), .TDATA(TDATA),
      .statusStrobe(statusStrobe), .statusCode(statusCode),
      .statusFMPSenabled(statusFMPSenabled), .fmpsBitmap(fmpsBitmap),
      .fmpsCounter(fmpsCounter), .readoutAddress(readoutAddress), .readoutFMPS(readoutFMPS)
   );

   always #5 auroraClk = ~auroraClk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge auroraClk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mkdata(input int i, input int c);
      logic [4:0] i5;
      logic [7:0] c8;
      i5 = 5'(i);
      c8 = 8'(c);
      return {3'b0, i5, 16'hCACA, c8};
   endfunction

   function automatic logic [31:0] mkhdr(input logic [15:0] magic, input logic [4:0] idx);
      return {magic, 1'b0, idx, 10'b0};
   endfunction

   task automatic send_word(input logic [31:0] d, input logic last);
      TVALID = 1'b1;
      TDATA  = d;
      TLAST  = last;
      tick();
      TVALID = 1'b0;
      TLAST  = 1'b0;
      TDATA  = '0;
   endtask

   // Header + one data word, then one idle cycle so the commit edge has passed.
   task automatic send_pkt(input logic [4:0] idx, input logic [31:0] d);
      send_word(mkhdr(16'hB6CF, idx), 1'b0);
      send_word(d, 1'b1);
      tick();
   endtask

   task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
      readoutAddress = a;
      tick();
      chk(name, readoutFMPS, exp);
   endtask

   task automatic strobe_chk(input string name, input logic [1:0] code, input logic en);
      FAstrobe = 1'b1;
      tick();
      FAstrobe = 1'b0;
      chk({name, "_strobe"}, statusStrobe, 1'b1);
      chk({name, "_code"}, statusCode, code);
      chk({name, "_en"}, statusFMPSenabled, en);
   endtask

   task automatic drain_sb(input string name);
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         read_chk(name, e.idx, e.data);
      end
   endtask

   initial begin
      for (int i = 0; i < 12; i++) begin
         vt[i].idx     = 5'(i);
         vt[i].data    = mkdata(i, i * 7 + 1);
         vt[i].exp_cnt = i + 1;
      end

      auroraReset = 1'b1; FAstrobe = 1'b0; allFMPSpresent = 1'b0;
      TVALID = 1'b0; TLAST = 1'b0; TDATA = '0; readoutAddress = '0;
      tick(); tick();
      auroraReset = 1'b0;
      chk("rst_bitmap", fmpsBitmap, 32'h0);
      chk("rst_counter", fmpsCounter, 6'd0);
      chk("rst_strobe", statusStrobe, 1'b0);
      chk("rst_code", statusCode, 2'd0);
      chk("rst_readout", readoutFMPS, 32'h0);

      // 12 good packets from the table
      for (int i = 0; i < 12; i++) begin
         send_pkt(vt[i].idx, vt[i].data);
         sb.push_back('{idx: vt[i].idx, data: vt[i].data});
         chk("tbl_counter", fmpsCounter, 6'(vt[i].exp_cnt));
      end
      chk("tbl_bitmap", fmpsBitmap, 32'hFFF);
      drain_sb("tbl_readout");

      // all present, frozen, strobe
      allFMPSpresent = 1'b1;
      tick();
      strobe_chk("allpresent", 2'd0, 1'b1);
      allFMPSpresent = 1'b0;
      chk("allpresent_bitmap", fmpsBitmap, 32'h0);
      chk("allpresent_counter", fmpsCounter, 6'd0);
      tick();
      chk("strobe_one_cycle", statusStrobe, 1'b0);

      // incomplete cycle of 5
      for (int i = 0; i < 5; i++) begin
         send_pkt(5'(i), mkdata(i, 8'h40 + i));
         sb.push_back('{idx: 5'(i), data: mkdata(i, 8'h40 + i)});
      end
      chk("five_counter", fmpsCounter, 6'd5);
      drain_sb("five_readout");
      strobe_chk("incomplete", 2'd1, 1'b1);

      // bad magic, then over-long packet, then a good one
      send_word(mkhdr(16'h1234, 5'd20), 1'b0);
      send_word(32'hDEAD0000, 1'b1);
      tick();
      chk("badmagic_bitmap", fmpsBitmap, 32'h0);
      send_word(mkhdr(16'hB6CF, 5'd21), 1'b0);
      send_word(32'h11111111, 1'b0);
      send_word(32'h22222222, 1'b0);
      send_word(32'h33333333, 1'b1);
      tick();
      chk("longpkt_bitmap", fmpsBitmap, 32'h0);
      send_pkt(5'd20, 32'h20202020);
      chk("after_err_bitmap", fmpsBitmap, 32'h1 << 20);
      chk("after_err_counter", fmpsCounter, 6'd1);
      read_chk("after_err_readout", 5'd20, 32'h20202020);
      strobe_chk("errcycle", 2'd2, 1'b1);

      // duplicate index 7
      send_pkt(5'd7, 32'hAAAA0007);
      send_pkt(5'd7, 32'hBBBB0007);
      chk("dup_counter", fmpsCounter, 6'd1);
      chk("dup_bitmap", fmpsBitmap, 32'h1 << 7);
      read_chk("dup_readout", 5'd7, 32'hAAAA0007);
      strobe_chk("dupcycle", 2'd2, 1'b1);

      // frozen: packet dropped, buffer untouched
      allFMPSpresent = 1'b1;
      tick();
      send_pkt(5'd9, 32'hC0C0C0C9);
      chk("frozen_bitmap", fmpsBitmap, 32'h0);
      chk("frozen_counter", fmpsCounter, 6'd0);
      read_chk("frozen_readout", 5'd9, vt[9].data);
      strobe_chk("frozencycle", 2'd0, 1'b0);
      allFMPSpresent = 1'b0;
      send_pkt(5'd9, 32'hC0C0C0C9);
      chk("unfrozen_bitmap", fmpsBitmap, 32'h1 << 9);
      chk("unfrozen_counter", fmpsCounter, 6'd1);
      read_chk("unfrozen_readout", 5'd9, 32'hC0C0C0C9);

      // commit on the strobe edge, with a TVALID gap inside the packet
      send_word(mkhdr(16'hB6CF, 5'd3), 1'b0);
      tick();
      send_word(32'hE0E0E003, 1'b1);
      strobe_chk("edgecommit", 2'd1, 1'b1);
      chk("edgecommit_bitmap", fmpsBitmap, 32'h1 << 3);
      chk("edgecommit_counter", fmpsCounter, 6'd1);
      read_chk("edgecommit_readout", 5'd3, 32'hE0E0E003);

      // write and read same address on the same edge returns old data
      readoutAddress = 5'd4;
      send_word(mkhdr(16'hB6CF, 5'd4), 1'b0);
      send_word(32'hD0D0D004, 1'b1);
      tick();
      chk("rw_same_old", readoutFMPS, mkdata(4, 8'h44));
      tick();
      chk("rw_same_new", readoutFMPS, 32'hD0D0D004);
      chk("rw_bitmap", fmpsBitmap, (32'h1 << 3) | (32'h1 << 4));
      chk("rw_counter", fmpsCounter, 6'd2);
      strobe_chk("final", 2'd1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
